lockpick_player: RTL

- Host-side driver for the lockpick game core: takes one guess (two 256-bit keys) per command and streams it into the game's byte-serial input port.
- Issues the game `start` pulse only when a new session is needed.
- Captures the game's 32-byte result stream and decodes it to win / error / lockout.
- Sits between a register/CPU-style command interface and the game core; used by the bench driver and by the on-chip demo sequencer.

---
 rtl/lockpick_player.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/lockpick_player.sv
// Host-side player for the lockpick game core.
// Streams a two-key guess into the game, collects and decodes its result.
module lockpick_player #(
  parameter int BYTE_GAP       = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [255:0] cmd_key_a,
  input  logic [255:0] cmd_key_b,
  output logic         game_start,
  output logic         game_input_enable,
  output logic [7:0]   game_input_data,
  input  logic         game_output_valid,
  input  logic [7:0]   game_output_data,
  input  logic [1:0]   game_status,
  output logic         rsp_valid,
  output logic [1:0]   rsp_code,
  output logic [1:0]   rsp_status,
  output logic         rsp_timeout,
  output logic [255:0] rsp_msg,
  output logic         session_active
);

  typedef enum logic [2:0] {
    P_IDLE, P_START, P_SEND_A, P_SEND_B,
    P_WAIT, P_RECV, P_DONE
  } state_t;

  localparam logic [3:0]  GAP      = 4'(BYTE_GAP);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] W_WIN    = 32'hFACEFACE;
  localparam logic [31:0] W_LOCK   = 32'hDEADDEAD;
  localparam logic [31:0] W_ERR    = 32'hBAD0BAD0;

  function automatic logic [1:0] decode(input logic [255:0] m);
    logic win, lock, err;
    win  = 1'b1;
    lock = 1'b1;
    err  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      win  &= (m[j*32 +: 32] == W_WIN);
      lock &= (m[j*32 +: 32] == W_LOCK);
      err  &= (m[j*32 +: 32] == W_ERR);
    end
    unique case (1'b1)
      win:     decode = 2'b10;
      lock:    decode = 2'b11;
      err:     decode = 2'b01;
      default: decode = 2'b00;
    endcase
  endfunction

  state_t         state, state_nxt;
  logic [255:0]   key_a, key_a_nxt;
  logic [255:0]   key_b, key_b_nxt;
  logic [255:0]   cap, cap_nxt;
  logic [4:0]     byte_cnt, byte_cnt_nxt;
  logic [3:0]     gap, gap_nxt;
  logic [7:0]     tmo, tmo_nxt;
  logic [4:0]     rx_cnt, rx_cnt_nxt;
  logic [1:0]     dec;

  logic           cmd_ready_nxt, game_start_nxt;
  logic           enable_nxt, rsp_valid_nxt;
  logic [7:0]     data_nxt;
  logic [1:0]     code_nxt, status_nxt;
  logic           timeout_nxt, session_nxt;
  logic [255:0]   msg_nxt;

  always_comb begin
    state_nxt    = state;
    key_a_nxt    = key_a;
    key_b_nxt    = key_b;
    cap_nxt      = cap;
    byte_cnt_nxt = byte_cnt;
    gap_nxt      = gap;
    tmo_nxt      = tmo;
    rx_cnt_nxt   = rx_cnt;
    dec          = 2'b00;
    code_nxt     = rsp_code;
    status_nxt   = rsp_status;
    timeout_nxt  = rsp_timeout;
    msg_nxt      = rsp_msg;
    session_nxt  = session_active;
    unique case (state)
      P_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          key_a_nxt    = cmd_key_a;
          key_b_nxt    = cmd_key_b;
          byte_cnt_nxt = '0;
          gap_nxt      = '0;
          if (session_active) begin
            state_nxt = P_SEND_A;
          end else begin
            state_nxt   = P_START;
            session_nxt = 1'b1;
          end
        end
      end
      P_START: state_nxt = P_SEND_A;
      P_SEND_A, P_SEND_B: begin
        if (state == P_SEND_B && byte_cnt == 5'd31 && gap == '0) begin
          state_nxt  = P_WAIT;
          tmo_nxt    = '0;
          rx_cnt_nxt = '0;
          cap_nxt    = '0;
        end else if (gap != GAP) begin
          gap_nxt = gap + 4'd1;
        end else begin
          gap_nxt      = '0;
          byte_cnt_nxt = byte_cnt + 5'd1;
          if (byte_cnt == 5'd31) state_nxt = P_SEND_B;
        end
      end
      P_WAIT: begin
        if (game_output_valid) begin
          cap_nxt[7:0] = game_output_data;
          rx_cnt_nxt   = 5'd1;
          state_nxt    = P_RECV;
        end else if (tmo == TMO_LAST) begin
          state_nxt   = P_DONE;
          code_nxt    = 2'b00;
          status_nxt  = 2'b00;
          timeout_nxt = 1'b1;
          msg_nxt     = '0;
          session_nxt = 1'b0;
        end else begin
          tmo_nxt = tmo + 8'd1;
        end
      end
      P_RECV: begin
        if (game_output_valid) begin
          cap_nxt[{rx_cnt, 3'b000} +: 8] = game_output_data;
          if (rx_cnt == 5'd31) begin
            dec         = decode(cap_nxt);
            state_nxt   = P_DONE;
            code_nxt    = dec;
            status_nxt  = game_status;
            timeout_nxt = 1'b0;
            msg_nxt     = cap_nxt;
            session_nxt = (dec == 2'b01);
          end else begin
            rx_cnt_nxt = rx_cnt + 5'd1;
          end
        end else begin
          // Stream broke early: report what arrived, as invalid.
          state_nxt   = P_DONE;
          code_nxt    = 2'b00;
          status_nxt  = 2'b00;
          timeout_nxt = 1'b0;
          msg_nxt     = cap;
          session_nxt = 1'b0;
        end
      end
      P_DONE:  state_nxt = P_IDLE;
      default: state_nxt = P_IDLE;
    endcase
    // Outputs are registered images of the state being entered.
    cmd_ready_nxt  = (state_nxt == P_IDLE);
    game_start_nxt = (state_nxt == P_START);
    rsp_valid_nxt  = (state_nxt == P_DONE);
    enable_nxt     = (state_nxt == P_SEND_A || state_nxt == P_SEND_B)
                     && gap_nxt == '0;
    data_nxt       = '0;
    if (enable_nxt) begin
      if (state_nxt == P_SEND_A)
        data_nxt = key_a_nxt[{byte_cnt_nxt, 3'b000} +: 8];
      else
        data_nxt = key_b_nxt[{byte_cnt_nxt, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= P_IDLE;
      key_a             <= '0;
      key_b             <= '0;
      cap               <= '0;
      byte_cnt          <= '0;
      gap               <= '0;
      tmo               <= '0;
      rx_cnt            <= '0;
      cmd_ready         <= 1'b1;
      game_start        <= 1'b0;
      game_input_enable <= 1'b0;
      game_input_data   <= '0;
      rsp_valid         <= 1'b0;
      rsp_code          <= '0;
      rsp_status        <= '0;
      rsp_timeout       <= 1'b0;
      rsp_msg           <= '0;
      session_active    <= 1'b0;
    end else begin
      state             <= state_nxt;
      key_a             <= key_a_nxt;
      key_b             <= key_b_nxt;
      cap               <= cap_nxt;
      byte_cnt          <= byte_cnt_nxt;
      gap               <= gap_nxt;
      tmo               <= tmo_nxt;
      rx_cnt            <= rx_cnt_nxt;
      cmd_ready         <= cmd_ready_nxt;
      game_start        <= game_start_nxt;
      game_input_enable <= enable_nxt;
      game_input_data   <= data_nxt;
      rsp_valid         <= rsp_valid_nxt;
      rsp_code          <= code_nxt;
      rsp_status        <= status_nxt;
      rsp_timeout       <= timeout_nxt;
      rsp_msg           <= msg_nxt;
      session_active    <= session_nxt;
    end
  end

endmodule
